// File: rtl/chk_1_if.sv
// Write-port bundle between the MBIST controller, the checkerboard
// generator and the memory-under-test.
//
// Request/complete handshake: the controller raises en_in to request a
// sweep and holds it high for the whole sweep. The generator answers with
// one w_en_out pulse per word (256 back-to-back cycles) and then raises
// rst_done. rst_done stays high until en_in is seen low, which both
// acknowledges completion and returns the generator to idle. Dropping
// en_in before rst_done aborts the sweep.
interface chk_1_if;
  logic       en_in;
  logic       rev_in;
  logic [3:0] dat_out;
  logic [7:0] addr_out;
  logic       w_en_out;
  logic       rst_done;

  modport master (
    output en_in, rev_in,
    input  dat_out, addr_out, w_en_out, rst_done
  );

  modport slave (
    input  en_in, rev_in,
    output dat_out, addr_out, w_en_out, rst_done
  );
endinterface

// File: rtl/chk_1.sv
// Checkerboard write-sequence generator for a 256x4 memory. Sweeps all
// addresses ascending (normal pattern) or descending (inverted pattern),
// one registered write per clock, then flags completion on rst_done.
module chk_1 (
  input  logic        clk,
  input  logic        rst_n,
  chk_1_if.slave      bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rev_q, rev_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  dat_q, dat_d;
  logic        w_en_q, w_en_d;
  logic        done_q, done_d;

  // Row bit 4 and column bit 0 together give the checkerboard parity.
  function automatic logic [3:0] pattern(input logic [7:0] a, input logic rev);
    return (a[0] ^ a[4] ^ rev) ? 4'b1010 : 4'b0101;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    w_en_d  = w_en_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        addr_d = 8'h00;
        dat_d  = 4'b0000;
        w_en_d = 1'b0;
        done_d = 1'b0;
        if (bus.en_in) begin
          // Direction is fixed for the whole sweep by rev_in seen here.
          rev_d   = bus.rev_in;
          addr_d  = bus.rev_in ? 8'hFF : 8'h00;
          dat_d   = pattern(bus.rev_in ? 8'hFF : 8'h00, bus.rev_in);
          w_en_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.en_in) begin
          addr_d  = 8'h00;
          dat_d   = 4'b0000;
          w_en_d  = 1'b0;
          done_d  = 1'b0;
          state_d = IDLE;
        end else if (addr_q == (rev_q ? 8'h00 : 8'hFF)) begin
          // Last word was written in the cycle just ending.
          w_en_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          addr_d = rev_q ? addr_q - 8'd1 : addr_q + 8'd1;
          dat_d  = pattern(rev_q ? addr_q - 8'd1 : addr_q + 8'd1, rev_q);
          w_en_d = 1'b1;
        end
      end
      DONE: begin
        w_en_d = 1'b0;
        done_d = 1'b1;
        if (!bus.en_in) begin
          addr_d  = 8'h00;
          dat_d   = 4'b0000;
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        addr_d  = 8'h00;
        dat_d   = 4'b0000;
        w_en_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rev_q   <= 1'b0;
      addr_q  <= 8'h00;
      dat_q   <= 4'b0000;
      w_en_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rev_q   <= rev_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      w_en_q  <= w_en_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.dat_out  = dat_q;
  assign bus.w_en_out = w_en_q;
  assign bus.rst_done = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_chk_1.sv
// Bench for the checkerboard generator: directed sweeps with a write
// scoreboard fed by the driver and drained by a negedge monitor.
module tb_chk_1;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  chk_1_if bus ();

  chk_1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected writes: {rev, addr[7:0], dat[3:0]}
  logic [12:0] exp_q[$];

  // Hand-computed checkerboard points: {rev, addr, dat}
  localparam int NHAND = 10;
  logic [12:0] hand_tbl [NHAND] = '{
    {1'b0, 8'h00, 4'b0101},
    {1'b0, 8'h01, 4'b1010},
    {1'b0, 8'h10, 4'b1010},
    {1'b0, 8'h11, 4'b0101},
    {1'b0, 8'h40, 4'b0101},
    {1'b0, 8'hFF, 4'b0101},
    {1'b1, 8'hFF, 4'b1010},
    {1'b1, 8'hFE, 4'b0101},
    {1'b1, 8'hE7, 4'b0101},
    {1'b1, 8'h00, 4'b1010}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_pat(input logic [7:0] a, input logic rev);
    return (a[0] ^ a[4] ^ rev) ? 4'b1010 : 4'b0101;
  endfunction

  task automatic chk_idle(input string name);
    chk({name, "_addr"}, {24'd0, bus.addr_out}, 32'h00);
    chk({name, "_dat"},  {28'd0, bus.dat_out},  32'h0);
    chk({name, "_wen"},  {31'd0, bus.w_en_out}, 32'h0);
    chk({name, "_done"}, {31'd0, bus.rst_done}, 32'h0);
  endtask

  // Monitor: every presented write is popped and compared
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (bus.w_en_out && bus.rst_done)
        chk("wen_and_done", 32'd1, 32'd0);
      if (bus.w_en_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, bus.addr_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, bus.addr_out}, {24'd0, e[11:4]});
          chk("wr_dat",  {28'd0, bus.dat_out},  {28'd0, e[3:0]});
          for (int k = 0; k < NHAND; k++)
            if (hand_tbl[k][12] == e[12] && hand_tbl[k][11:4] == bus.addr_out)
              chk("hand_dat", {28'd0, bus.dat_out}, {28'd0, hand_tbl[k][3:0]});
        end
      end
    end
  end

  // Driver: hold en_in high for n sampling edges, then drop it
  task automatic sweep(input int n, input logic rev, input bit toggle);
    int nw;
    logic [7:0] a;
    logic [7:0] end_a;
    nw = (n < 256) ? n : 256;
    for (int i = 0; i < nw; i++) begin
      a = rev ? 8'(255 - i) : 8'(i);
      exp_q.push_back({rev, a, model_pat(a, rev)});
    end
    bus.rev_in = rev;
    bus.en_in  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (toggle) bus.rev_in = ~bus.rev_in;
    end
    if (n >= 257) begin
      end_a = rev ? 8'h00 : 8'hFF;
      chk("done_flag", {31'd0, bus.rst_done}, 32'd1);
      chk("done_wen",  {31'd0, bus.w_en_out}, 32'd0);
      chk("done_addr", {24'd0, bus.addr_out}, {24'd0, end_a});
      chk("done_dat",  {28'd0, bus.dat_out},  rev ? 32'hA : 32'h5);
      chk("drained",   exp_q.size(), 32'd0);
    end
    bus.en_in = 1'b0;
    @(posedge clk); #1;
    chk_idle("after_drop");
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.en_in  = 1'b1;
    bus.rev_in = 1'b0;
    // Reset held with en_in high: nothing may start
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_idle("in_reset");
    end
    bus.en_in = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_reset");

    // Forward sweep, completion handshake, restart with rev_in toggling
    sweep(260, 1'b0, 1'b0);
    sweep(260, 1'b0, 1'b1);

    // Reverse sweep
    sweep(260, 1'b1, 1'b0);

    // Abort after 26 writes (0xFF..0xE6); done must never assert
    sweep(26, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle("after_abort");
    end
    chk("abort_drained", exp_q.size(), 32'd0);

    // Async reset while writing address 0x40
    for (int i = 0; i <= 8'h40; i++)
      exp_q.push_back({1'b0, 8'(i), model_pat(8'(i), 1'b0)});
    bus.rev_in = 1'b0;
    bus.en_in  = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_addr", {24'd0, bus.addr_out}, 32'h40);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    bus.en_in = 1'b0;
    @(posedge clk); #1;
    chk_idle("rst_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst_release");
    chk("rst_drained", exp_q.size(), 32'd0);

    // Restart after reset begins at 0x00
    sweep(260, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
